fetch_ctrl: RTL

//  Fetch sequencer for the synchronous instruction ROM block (1-cycle read latency, word-addressed).

---
 rtl/fetch_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl
// ----------------------------------------------------------------------------
// Fetch sequencer sitting between the synchronous instruction ROM (1-cycle
// read latency, word addressed) and the decode stage.
//
//  * Owns the fetch PC and issues at most one ROM read per cycle.
//  * Returned words are tagged with their byte address and buffered in a
//    2-entry FIFO whose head drives inst/inst_pc.
//  * A redirect flushes the FIFO and kills the read whose data is returning
//    this cycle, then issues the redirect target in the same cycle.
//  * A misaligned redirect target is fatal: the block enters HALT, raises
//    the sticky fault flag and stops fetching until reset.
//
// Handshake (decode side): a word moves to decode on every rising CLK edge
// where inst_valid && inst_ready. While inst_valid is high and inst_ready is
// low, inst/inst_pc hold steady. inst_ready with inst_valid low is ignored.
//
// Ports
//  CLK          in   1       clock, all state updates on posedge
//  NRST         in   1       asynchronous active-low reset
//  rom_en       out  1       ROM read strobe (sampled by ROM at posedge)
//  rom_addr     out  ADDR_W  ROM word address of the read
//  rom_data     in   32      ROM read data, valid the cycle after rom_en
//  redirect     in   1       flush and restart fetch at redirect_pc
//  redirect_pc  in   32      new fetch byte address
//  inst_valid   out  1       inst/inst_pc hold a valid instruction
//  inst_ready   in   1       decode accepts the instruction
//  inst         out  32      instruction word (FIFO head)
//  inst_pc      out  32      byte address of inst
//  fault        out  1       sticky misaligned-redirect flag, fetch halted
// ============================================================================
module fetch_ctrl #(
   parameter logic [31:0] START_PC = 32'h0000_8000,
   parameter int          ADDR_W   = 15
) (
   input  logic              CLK,
   input  logic              NRST,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst,
   output logic [31:0]       inst_pc,
   output logic              fault
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t       r_state;
   logic [31:0]  r_fetch_pc;     // byte address of the next sequential fetch
   logic         r_inflight;     // a read issued last cycle returns now
   logic [31:0]  r_tag;          // byte address of the returning read
   logic [31:0]  r_fifo_inst [2];
   logic [31:0]  r_fifo_pc   [2];
   logic         r_rd_ptr;
   logic         r_wr_ptr;
   logic [1:0]   r_count;
   logic         r_fault;

   // ------------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------------
   logic              w_run;
   logic              w_redir_ok;
   logic              w_redir_bad;
   logic              w_valid;
   logic              w_pop;
   logic              w_push;
   logic [2:0]        w_occ;
   logic              w_issue_seq;
   logic              w_issue;
   logic [ADDR_W-1:0] w_issue_word;

   always_comb begin
      w_run       = (r_state == ST_RUN);
      w_redir_ok  = w_run && redirect && (redirect_pc[1:0] == 2'b00);
      w_redir_bad = w_run && redirect && (redirect_pc[1:0] != 2'b00);

      // A redirect suppresses delivery in its own cycle so nothing from the
      // old stream leaks past the flush.
      w_valid = w_run && (r_count != 2'd0) && !redirect;
      w_pop   = w_valid && inst_ready;

      // Returning data is accepted only when not being flushed.
      w_push  = w_run && !redirect && r_inflight;

      // Occupancy the FIFO will have once this cycle's pop and the returning
      // read settle; a new read is only started if its data will fit.
      w_occ = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

      w_issue_seq = w_run && !redirect && (w_occ < 3'd2);
      w_issue     = w_issue_seq || w_redir_ok;

      // Redirect target is fetched in the same cycle, no extra bubble.
      w_issue_word = w_redir_ok ? redirect_pc[ADDR_W+1:2]
                                : r_fetch_pc[ADDR_W+1:2];
   end

   // rom_en is gated by NRST so the ROM sees no strobe while reset is held.
   assign rom_en     = w_issue && NRST;
   assign rom_addr   = w_issue_word;
   assign inst_valid = w_valid;
   assign inst       = r_fifo_inst[r_rd_ptr];
   assign inst_pc    = r_fifo_pc[r_rd_ptr];
   assign fault      = r_fault;

   // ------------------------------------------------------------------------
   // Sequencer, FIFO and fetch PC
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         r_state    <= ST_RUN;
         r_fetch_pc <= START_PC;
         r_inflight <= 1'b0;
         r_tag      <= 32'd0;
         r_rd_ptr   <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_count    <= 2'd0;
         r_fault    <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            r_fifo_inst[i] <= 32'd0;
            r_fifo_pc[i]   <= 32'd0;
         end
      end else begin
         case (r_state)
            ST_RUN: begin
               if (redirect) begin
                  // Flush buffered words; the returning read is dropped by
                  // not pushing it.
                  r_count  <= 2'd0;
                  r_rd_ptr <= 1'b0;
                  r_wr_ptr <= 1'b0;
                  if (w_redir_ok) begin
                     r_fetch_pc <= redirect_pc + 32'd4;
                     r_tag      <= redirect_pc;
                     r_inflight <= 1'b1;
                  end else if (w_redir_bad) begin
                     r_inflight <= 1'b0;
                     r_fault    <= 1'b1;
                     r_state    <= ST_HALT;
                  end
               end else begin
                  if (w_push) begin
                     r_fifo_inst[r_wr_ptr] <= rom_data;
                     r_fifo_pc[r_wr_ptr]   <= r_tag;
                     r_wr_ptr              <= ~r_wr_ptr;
                  end
                  if (w_pop) begin
                     r_rd_ptr <= ~r_rd_ptr;
                  end
                  r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

                  if (w_issue_seq) begin
                     r_fetch_pc <= r_fetch_pc + 32'd4;   // wraps mod 2^32
                     r_tag      <= r_fetch_pc;
                     r_inflight <= 1'b1;
                  end else begin
                     r_inflight <= 1'b0;
                  end
               end
            end

            ST_HALT: begin
               // Terminal until reset; redirects are ignored here.
               r_fault    <= 1'b1;
               r_inflight <= 1'b0;
               r_count    <= 2'd0;
            end
         endcase
      end
   end

endmodule
